// File: rtl/bin_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bin_bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one shift/add-3 step per clock,
// with saturation to all nines on overflow and a leading-zero blanking mask.
module bin_bcd_seq
  import bin_bcd_pkg::*;
#(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     lz_mask,
  output logic                  overflow
);

  localparam int DW = 4 * DIGITS;
  localparam int SW = DW + BIN_W;
  localparam int CW = clog2(BIN_W + 1);

  localparam logic [CW-1:0]     CNT_LOAD = CW'(BIN_W);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [DIGITS-1:0] LZ_RESET = {DIGITS{1'b1}} << 1;

  state_t            state_reg;
  logic [SW-1:0]     sr_reg;
  logic [CW-1:0]     cnt_reg;
  logic              ovf_reg;

  logic [DW-1:0]     adj_digits;
  logic [SW-1:0]     sr_next;
  logic              ovf_next;
  logic [DW-1:0]     bcd_next;
  logic [DIGITS-1:0] lz_next;
  logic              zero_run;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (sr_reg[BIN_W + 4*gi +: 4]),
        .dout (adj_digits[4*gi +: 4])
      );
    end
  endgenerate

  // The bit leaving the top digit means the value no longer fits; remember it.
  always_comb begin
    sr_next  = {adj_digits[DW-2:0], sr_reg[BIN_W-1:0], 1'b0};
    ovf_next = ovf_reg | adj_digits[DW-1];
    bcd_next = ovf_next ? {DIGITS{BCD_NINE}} : sr_next[SW-1:BIN_W];
    lz_next  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (bcd_next[4*i +: 4] == 4'd0);
      lz_next[i] = zero_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      lz_mask   <= LZ_RESET;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            sr_reg    <= {{DW{1'b0}}, binary};
            ovf_reg   <= 1'b0;
            cnt_reg   <= CNT_LOAD;
            busy      <= 1'b1;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr_reg  <= sr_next;
          ovf_reg <= ovf_next;
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            bcd       <= bcd_next;
            lz_mask   <= lz_next;
            overflow  <= ovf_next;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
